// File: rtl/sand_pkg.sv
// Shared types for the sand sweep controller.
// Pixel encoding, word geometry and sweep FSM states.
package sand_pkg;

  localparam int PX_W        = 2;
  localparam int PX_PER_WORD = 16;
  localparam int WORD_W      = PX_W * PX_PER_WORD;

  typedef enum logic [1:0] {
    AIR     = 2'b00,
    SAND    = 2'b01,
    SAND_AM = 2'b10,
    WALL    = 2'b11
  } px_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_R,
    RD_F,
    CAP,
    CALC,
    WR_F,
    WR_R,
    NEXT,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/sand_sweep_ctrl_if.sv
// Frame-RAM arbiter port of the sweep controller.
// Request/grant access; read data returns one cycle after grant.
interface sand_sweep_ctrl_if #(
  parameter int ADDR_W = 15
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_gnt,
    output mem_rdata
  );

endinterface

// File: rtl/sand_sweep_addr.sv
// Row/column walker for the bottom-up sweep.
// Row base steps down by COLS_W per row, so no multiplier.
module sand_sweep_addr #(
  parameter int COLS_W = 40,
  parameter int ROWS   = 480,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] region_addr_o,
  output logic [ADDR_W-1:0] floor_addr_o,
  output logic              begin_o,
  output logic              end_o,
  output logic              bottom_o,
  output logic              last_o
);

  localparam int CW = (COLS_W > 1) ? $clog2(COLS_W) : 1;
  localparam int RW = $clog2(ROWS);

  localparam logic [ADDR_W-1:0] BASE0 =
    ADDR_W'((ROWS - 2) * COLS_W);
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(COLS_W);
  localparam logic [CW-1:0] COL_LAST =
    CW'(COLS_W - 1);
  localparam logic [RW-1:0] ROW_TOP =
    RW'(ROWS - 2);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;

  // Counter next-state: load top row on init, step on advance.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (init_i) begin
      col_d  = '0;
      row_d  = ROW_TOP;
      base_d = BASE0;
    end else if (adv_i) begin
      if (col_q == COL_LAST) begin
        col_d  = '0;
        row_d  = row_q - 1'b1;
        base_d = base_q - STEP;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

  assign region_addr_o = base_q + ADDR_W'(col_q);
  assign floor_addr_o  = base_q + STEP + ADDR_W'(col_q);
  assign begin_o       = (col_q == '0);
  assign end_o         = (col_q == COL_LAST);
  assign bottom_o      = (row_q == ROW_TOP);
  assign last_o        = end_o && (row_q == '0);

endmodule

// File: rtl/sand_sweep_ctrl.sv
// Per-frame sweep controller feeding sand_update.
// Reads region/floor words, writes back only changed words.
module sand_sweep_ctrl
  import sand_pkg::*;
#(
  parameter int COLS_W = 40,
  parameter int ROWS   = 480,
  parameter int ADDR_W = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  sand_sweep_ctrl_if.master mem,
  output logic [31:0]  upd_region,
  output logic [31:0]  upd_floor,
  output logic         upd_begin,
  output logic         upd_end,
  output logic         upd_bottom,
  input  logic [31:0]  upd_new_region,
  input  logic [31:0]  upd_new_floor
);

  sweep_state_t state_q, state_d;

  logic        busy_q, busy_d;
  logic        rdv_q, rdv_d;
  logic [31:0] region_q, region_d;
  logic [31:0] floor_q, floor_d;
  logic [31:0] nr_q, nr_d;
  logic [31:0] nf_q, nf_d;

  logic              init, adv;
  logic              req, we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  logic [ADDR_W-1:0] ra, fa;
  logic              f_begin, f_end, f_bottom, last;

  sand_sweep_addr #(
    .COLS_W (COLS_W),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk           (clk),
    .reset_n       (reset_n),
    .init_i        (init),
    .adv_i         (adv),
    .region_addr_o (ra),
    .floor_addr_o  (fa),
    .begin_o       (f_begin),
    .end_o         (f_end),
    .bottom_o      (f_bottom),
    .last_o        (last)
  );

  // Next state, data capture and RAM request decode.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    rdv_d    = 1'b0;
    region_d = region_q;
    floor_d  = floor_q;
    nr_d     = nr_q;
    nf_d     = nf_q;
    init     = 1'b0;
    adv      = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_R;
          busy_d  = 1'b1;
          init    = 1'b1;
        end
      end
      RD_R: begin
        req  = 1'b1;
        addr = ra;
        if (mem.mem_gnt) begin
          state_d = RD_F;
          rdv_d   = 1'b1;
        end
      end
      RD_F: begin
        req  = 1'b1;
        addr = fa;
        // rdata is only valid right after the region grant
        if (rdv_q) region_d = mem.mem_rdata;
        if (mem.mem_gnt) state_d = CAP;
      end
      CAP: begin
        floor_d = mem.mem_rdata;
        state_d = CALC;
      end
      CALC: begin
        nr_d = upd_new_region;
        nf_d = upd_new_floor;
        if (upd_new_floor != floor_q)
          state_d = WR_F;
        else if (upd_new_region != region_q)
          state_d = WR_R;
        else
          state_d = NEXT;
      end
      WR_F: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = fa;
        wdata = nf_q;
        if (mem.mem_gnt)
          state_d = (nr_q != region_q) ? WR_R : NEXT;
      end
      WR_R: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ra;
        wdata = nr_q;
        if (mem.mem_gnt) state_d = NEXT;
      end
      NEXT: begin
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end else begin
          adv     = 1'b1;
          state_d = RD_R;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      rdv_q    <= 1'b0;
      region_q <= '0;
      floor_q  <= '0;
      nr_q     <= '0;
      nf_q     <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      rdv_q    <= rdv_d;
      region_q <= region_d;
      floor_q  <= floor_d;
      nr_q     <= nr_d;
      nf_q     <= nf_d;
    end
  end

  assign busy = busy_q;
  assign done = (state_q == DONE);

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

  assign upd_region = region_q;
  assign upd_floor  = floor_q;
  assign upd_begin  = busy_q & f_begin;
  assign upd_end    = busy_q & f_end;
  assign upd_bottom = busy_q & f_bottom;

endmodule

// File: tb/tb_sand_sweep_ctrl.sv
// Directed bench for sand_sweep_ctrl on a 2x4 word grid.
// RAM model with one-cycle read latency and a stub update stage.
module tb_sand_sweep_ctrl;

  localparam int CWD = 2;
  localparam int RWS = 4;
  localparam int AW  = 4;
  localparam int NW  = CWD * RWS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic        upd_begin, upd_end, upd_bottom;
  logic [31:0] upd_region, upd_floor;
  logic [31:0] upd_new_region, upd_new_floor;

  bit          xr_en = 1'b0;
  bit          stall_en = 1'b0;
  bit          block_wr = 1'b0;
  logic        stall_gnt = 1'b1;
  logic [31:0] rd_q = '0;

  bit          tb_clr = 1'b0;
  bit          ram_load = 1'b0;
  bit          ram_pat = 1'b0;

  logic [31:0] ram [NW];
  logic [31:0] mdl [NW];
  logic [63:0] log_acc [64];
  logic [63:0] exp_acc [64];
  int          log_n = 0;
  int          exp_n = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  bit          rd_par = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  sand_sweep_ctrl_if #(.ADDR_W(AW)) mif ();

  assign mif.mem_gnt =
    stall_gnt & ~(block_wr & mif.mem_req & mif.mem_we);
  assign mif.mem_rdata = rd_q;

  assign upd_new_region =
    xr_en ? (upd_region ^ 32'h1) : upd_region;
  assign upd_new_floor =
    xr_en ? (upd_floor ^ 32'h1) : upd_floor;

  sand_sweep_ctrl #(
    .COLS_W (CWD),
    .ROWS   (RWS),
    .ADDR_W (AW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .mem            (mif),
    .upd_region     (upd_region),
    .upd_floor      (upd_floor),
    .upd_begin      (upd_begin),
    .upd_end        (upd_end),
    .upd_bottom     (upd_bottom),
    .upd_new_region (upd_new_region),
    .upd_new_floor  (upd_new_floor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pv(input int i);
    return 32'h5A00_0000 | (i << 8) | (i * 3);
  endfunction

  // RAM model, access log and activity counters
  always @(posedge clk) begin
    if (tb_clr) begin
      log_n    = 0;
      busy_cnt = 0;
      done_cnt = 0;
      rd_par   = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mif.mem_req && mif.mem_gnt) begin
        if (mif.mem_we) begin
          log_acc[log_n] = {27'd0, 1'b1, mif.mem_addr,
                            mif.mem_wdata};
          ram[mif.mem_addr] = mif.mem_wdata;
        end else begin
          log_acc[log_n] = {27'd0, 1'b0, mif.mem_addr,
                            32'd0};
          rd_q <= ram[mif.mem_addr];
          if (rd_par) begin
            chk("flags",
                {upd_begin, upd_end, upd_bottom},
                {(mif.mem_addr % 2) == 0,
                 (mif.mem_addr % 2) == 1,
                 mif.mem_addr >= 4'd6});
          end
          rd_par = ~rd_par;
        end
        if (log_n < 63) log_n++;
      end
    end
    if (ram_load) begin
      for (int i = 0; i < NW; i++)
        ram[i] = ram_pat ? pv(i) : 32'd0;
    end
  end

  int          stall_left = 0;
  bit          fresh = 1'b0;
  bit          pend = 1'b0;
  bit          trig_f = 1'b0;
  bit          trig_r = 1'b0;
  logic [AW-1:0] h_addr;
  logic        h_we;
  logic [31:0] h_wd;

  task automatic hold_chk();
    chk("hold",
        {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata},
        {1'b1, h_we, h_addr, h_wd});
  endtask

  // Grant stalls: 3 cycles on the first floor read of addr 6
  // and on the first write to addr 4
  always @(negedge clk) begin
    if (!stall_en) begin
      stall_gnt  = 1'b1;
      stall_left = 0;
      pend       = 1'b0;
    end else begin
      if (stall_left == 0 && !pend && mif.mem_req) begin
        if (!trig_f && !mif.mem_we && mif.mem_addr == 4'd6) begin
          trig_f = 1'b1;
          stall_left = 3;
        end else if (!trig_r && mif.mem_we &&
                     mif.mem_addr == 4'd4) begin
          trig_r = 1'b1;
          stall_left = 3;
        end
        if (stall_left != 0) begin
          h_addr = mif.mem_addr;
          h_we   = mif.mem_we;
          h_wd   = mif.mem_wdata;
          fresh  = 1'b1;
        end
      end
      if (stall_left > 0) begin
        if (!fresh) hold_chk();
        fresh = 1'b0;
        stall_gnt = 1'b0;
        stall_left--;
        pend = (stall_left == 0);
      end else if (pend) begin
        hold_chk();
        pend = 1'b0;
        stall_gnt = 1'b1;
      end else begin
        stall_gnt = 1'b1;
      end
    end
  end

  task automatic load(input bit p);
    @(negedge clk);
    tb_clr   = 1'b1;
    ram_load = 1'b1;
    ram_pat  = p;
    @(negedge clk);
    tb_clr   = 1'b0;
    ram_load = 1'b0;
  endtask

  task automatic build_exp(input bit p, input bit xr);
    int ra;
    int fa;
    for (int i = 0; i < NW; i++) mdl[i] = p ? pv(i) : 32'd0;
    exp_n = 0;
    for (int r = RWS - 2; r >= 0; r--) begin
      for (int c = 0; c < CWD; c++) begin
        ra = r * CWD + c;
        fa = ra + CWD;
        exp_acc[exp_n++] = {27'd0, 1'b0, 4'(ra), 32'd0};
        exp_acc[exp_n++] = {27'd0, 1'b0, 4'(fa), 32'd0};
        if (xr) begin
          mdl[fa] = mdl[fa] ^ 32'h1;
          mdl[ra] = mdl[ra] ^ 32'h1;
          exp_acc[exp_n++] = {27'd0, 1'b1, 4'(fa), mdl[fa]};
          exp_acc[exp_n++] = {27'd0, 1'b1, 4'(ra), mdl[ra]};
        end
      end
    end
  endtask

  task automatic cmp_log(input string t);
    chk({t, "_len"}, log_n, exp_n);
    for (int i = 0; i < exp_n; i++)
      chk($sformatf("%s_acc%0d", t, i), log_acc[i], exp_acc[i]);
  endtask

  task automatic cmp_ram(input string t);
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s_ram%0d", t, i), ram[i], mdl[i]);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", n < 400, 1);
  endtask

  task automatic run_sweep();
    do_start();
    wait_done();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_wd", mif.mem_wdata, 0);
    chk("rst_upd", {upd_begin, upd_end, upd_bottom,
                    upd_region, upd_floor}, 0);
    reset_n = 1'b1;

    // all-AIR grid: reads only
    load(1'b0);
    xr_en = 1'b0;
    build_exp(1'b0, 1'b0);
    run_sweep();
    cmp_log("air");
    chk("air_busy", busy_cnt, 30);
    chk("air_done", done_cnt, 1);
    chk("air_idle", busy, 0);

    // every word changes: floor then region writes
    load(1'b1);
    xr_en = 1'b1;
    build_exp(1'b1, 1'b1);
    run_sweep();
    cmp_log("xor");
    cmp_ram("xor");
    chk("xor_done", done_cnt, 1);

    // same sweep with grant stalls
    load(1'b1);
    stall_en = 1'b1;
    run_sweep();
    chk("stall_hits", {trig_f, trig_r}, 2'b11);
    stall_en = 1'b0;
    cmp_log("stl");
    cmp_ram("stl");

    // start while busy is ignored
    load(1'b1);
    xr_en = 1'b0;
    build_exp(1'b1, 1'b0);
    do_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    chk("ign_done", done_cnt, 1);
    chk("ign_len", log_n, 12);
    chk("ign_busy", busy, 0);

    // reset during an ungranted floor write
    load(1'b1);
    xr_en = 1'b1;
    block_wr = 1'b1;
    do_start();
    n = 0;
    while (!(mif.mem_req && mif.mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wrf_seen", n < 100, 1);
    chk("wrf_addr", mif.mem_addr, 6);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_req", mif.mem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_drop", ram[6], pv(6));
    @(negedge clk);
    reset_n  = 1'b1;
    block_wr = 1'b0;
    load(1'b1);
    do_start();
    n = 0;
    while (log_n == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_first", log_acc[0],
        {27'd0, 1'b0, 4'd4, 32'd0});
    wait_done();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
